// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display: one shared hex decoder,
// guard blanking between slots, leading-zero suppression and frame-aligned updates.
module seg_scan_ctrl #(
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] display;
    logic [4*DIGITS-1:0] pending;
    logic                pending_full;

    logic [DIV_W-1:0]    div_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [4*DIGITS-1:0] display_nx;
    logic                last_slot_cyc;
    logic                frame_end;
    logic                commit;
    logic                transfer;
    logic                drive_nx;
    logic                blank_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] nibble(input logic [4*DIGITS-1:0] v,
                                          input logic [IDX_W-1:0] k);
        nibble = '0;
        for (int i = 0; i < DIGITS; i++)
            if (k == IDX_W'(i)) nibble = v[4*i +: 4];
    endfunction

    // Digit k>0 is a leading zero when it and every more significant nibble are zero.
    function automatic logic lz_blank(input logic [4*DIGITS-1:0] v,
                                      input logic [IDX_W-1:0] k,
                                      input logic en);
        logic z;
        z = (k != '0);
        for (int i = 0; i < DIGITS; i++)
            if (IDX_W'(i) >= k && v[4*i +: 4] != 4'h0) z = 1'b0;
        lz_blank = z && en;
    endfunction

    function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] k);
        onehot = '0;
        for (int i = 0; i < DIGITS; i++)
            if (k == IDX_W'(i)) onehot[i] = 1'b1;
    endfunction

    always_comb begin
        last_slot_cyc = (div == DIV_LAST);
        frame_end     = last_slot_cyc && (idx == IDX_LAST);
        div_nx        = last_slot_cyc ? '0 : div + 1'b1;
        idx_nx        = idx;
        if (last_slot_cyc)
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        commit        = frame_end && pending_full;
        transfer      = value_valid && !pending_full;
        display_nx    = commit ? pending : display;
        drive_nx      = (div_nx >= GUARD_V);
        blank_nx      = lz_blank(display_nx, idx_nx, blank_lz);
    end

    // Outputs are registered from the next-cycle state so they match the phase of that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div          <= '0;
            idx          <= '0;
            display      <= '0;
            pending_full <= 1'b0;
            seg          <= '0;
            digit_en     <= '0;
            frame_done   <= 1'b0;
        end else begin
            div          <= div_nx;
            idx          <= idx_nx;
            display      <= display_nx;
            pending_full <= transfer ? 1'b1 : (commit ? 1'b0 : pending_full);
            frame_done   <= frame_end;
            if (drive_nx && !blank_nx) begin
                seg      <= hex7(nibble(display_nx, idx_nx));
                digit_en <= onehot(idx_nx);
            end else begin
                seg      <= '0;
                digit_en <= '0;
            end
        end
    end

    // Pending data is only meaningful while pending_full is set, so it needs no reset.
    always_ff @(posedge clock) begin
        if (transfer) pending <= value_in;
    end

    assign value_ready = !pending_full;

endmodule
